onehot_seq_gen: RTL

ONEHOT_SEQ_GEN -- requirements
Module: onehot_seq_gen

---
 rtl/onehot_seq_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/onehot_seq_gen.sv
// onehot_seq_gen: emits bursts of one-hot words that walk a bit position up or down,
// with valid/ready handshaking, wrap/done/err pulses and flush/abort.
module onehot_seq_gen #(
    parameter int WIDTH = 32,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IW-1:0]    load_idx,
    input  logic [7:0]       load_len,
    input  logic             load_dir,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] onehot_out,
    output logic [IW-1:0]    idx_out,
    output logic             wrap,
    output logic             done,
    output logic             err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] pos;
    logic [7:0]    remaining;
    logic          dir;
    logic          legal;
    logic          xfer;
    logic          last;
    logic          at_top;
    logic          at_bot;
    logic [IW-1:0] nxt;
    logic          nxt_wrap;

    assign load_ready = state == IDLE;
    assign out_valid  = state == RUN;
    assign legal      = (int'(load_idx) < WIDTH) && load_len != 8'd0;
    assign xfer       = out_valid && out_ready;
    assign last       = remaining == 8'd1;
    assign at_top     = pos == IW'(WIDTH - 1);
    assign at_bot     = pos == '0;
    assign nxt        = dir ? (at_bot ? IW'(WIDTH - 1) : pos - IW'(1))
                            : (at_top ? '0 : pos + IW'(1));
    assign nxt_wrap   = dir ? at_bot : at_top;
    // The word is decoded from the held position, so it is one-hot by construction.
    assign onehot_out = WIDTH'(1) << pos;
    assign idx_out    = pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                err <= load_valid && !legal;
                if (load_valid && legal) begin
                    state     <= RUN;
                    pos       <= load_idx;
                    dir       <= load_dir;
                    remaining <= load_len;
                end
            end else begin
                if (xfer && last) begin
                    remaining <= '0;
                    done      <= !flush;
                end else if (xfer) begin
                    remaining <= remaining - 8'd1;
                    pos       <= nxt;
                    wrap      <= nxt_wrap;
                end
                if (flush)
                    remaining <= '0;
                if (flush || (xfer && last))
                    state <= IDLE;
            end
        end
    end
endmodule
